// File: rtl/mux_pkg.sv
// Shared types and constants for the 4:1 mux select arbiter.
// Holds the channel/select widths, the arbiter state enum and a small select-to-grant helper.
package mux_pkg;

    localparam int N_CH   = 4;
    localparam int SEL_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [N_CH-1:0] sel2gnt(input logic [SEL_W-1:0] s);
        return N_CH'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set bit of req, scanning upward from start mod 4.
// any is low when req is all zero; idx is then don't-care and driven to zero.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            // 2-bit add wraps naturally, giving the mod-4 scan order
            cand = start + SEL_W'(i);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin owner of the 4:1 mux select: one-hot grant, bounded hold, back-to-back handover.
// All outputs come straight from registers; sel tracks the owner and holds it while idle.
module rr_sel_arbiter4
    import mux_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             rel,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  gnt,
    output logic             valid,
    output logic             tmo
);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  own_q, own_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [N_CH-1:0]   gnt_q, gnt_d;
    logic              tmo_q, tmo_d;

    logic [SEL_W-1:0]  own_next;
    logic [SEL_W-1:0]  pick_start;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hold_expired;
    logic              grant_end;

    assign own_next     = own_q + SEL_W'(1);
    assign hold_expired = (hcnt_q == HOLD_W'(HOLD_MAX - 1));
    assign grant_end    = rel || !req[own_q] || hold_expired;

    // Single picker: idle scans from ptr, a finishing grant scans from just past the owner
    assign pick_start = (state_q == GRANT) ? own_next : ptr_q;

    rr_pick4 u_pick (
        .req   (req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    state_d = GRANT;
                    own_d   = pick_idx;
                    gnt_d   = sel2gnt(pick_idx);
                    hcnt_d  = '0;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    ptr_d = own_next;
                    tmo_d = hold_expired && !rel && req[own_q];
                    if (pick_any) begin
                        own_d  = pick_idx;
                        gnt_d  = sel2gnt(pick_idx);
                        hcnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    hcnt_d = hcnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            hcnt_q  <= '0;
            gnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign sel   = own_q;
    assign gnt   = gnt_q;
    assign valid = |gnt_q;
    assign tmo   = tmo_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Bench for rr_sel_arbiter4: three instances (HOLD_MAX 3, 2, default) share one stimulus stream
// and are checked every cycle against a cycle-count model of the arbitration rules.
module tb_rr_sel_arbiter4;

    localparam int NDUT = 3;
    localparam int HM[NDUT] = '{3, 2, 15};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rel;

    logic [1:0] sel_v[NDUT];
    logic [3:0] gnt_v[NDUT];
    logic       valid_v[NDUT];
    logic       tmo_v[NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    // model state: owner -1 means idle; held counts cycles the current grant has been visible
    int m_own[NDUT];
    int m_held[NDUT];
    int m_ptr[NDUT];
    int m_sel[NDUT];
    bit m_tmo[NDUT];

    always #5 clk = ~clk;

    rr_sel_arbiter4 #(.HOLD_MAX(3)) u_hm3 (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .sel(sel_v[0]), .gnt(gnt_v[0]), .valid(valid_v[0]), .tmo(tmo_v[0])
    );

    rr_sel_arbiter4 #(.HOLD_MAX(2)) u_hm2 (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .sel(sel_v[1]), .gnt(gnt_v[1]), .valid(valid_v[1]), .tmo(tmo_v[1])
    );

    rr_sel_arbiter4 u_hmdef (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .sel(sel_v[2]), .gnt(gnt_v[2]), .valid(valid_v[2]), .tmo(tmo_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic r, input logic [3:0] rq, input logic rl);
        int  w;
        bit  timed;
        m_tmo[d] = 1'b0;
        if (r) begin
            m_own[d]  = -1;
            m_held[d] = 0;
            m_ptr[d]  = 0;
            m_sel[d]  = 0;
        end else if (m_own[d] < 0) begin
            w = pick(rq, m_ptr[d]);
            if (w >= 0) begin
                m_own[d]  = w;
                m_sel[d]  = w;
                m_held[d] = 1;
            end
        end else begin
            timed = (m_held[d] == HM[d]);
            if (rl || !rq[m_own[d]] || timed) begin
                m_tmo[d] = timed && !rl && rq[m_own[d]];
                m_ptr[d] = (m_own[d] + 1) % 4;
                w = pick(rq, m_ptr[d]);
                if (w >= 0) begin
                    m_own[d]  = w;
                    m_sel[d]  = w;
                    m_held[d] = 1;
                end else begin
                    m_own[d] = -1;
                end
            end else begin
                m_held[d]++;
            end
        end
    endtask

    task automatic check_all(input int d);
        logic [3:0] eg;
        eg = (m_own[d] < 0) ? 4'b0000 : 4'(1 << m_own[d]);
        check($sformatf("gnt[%0d]", d), 32'(gnt_v[d]), 32'(eg));
        check($sformatf("sel[%0d]", d), 32'(sel_v[d]), 32'(m_sel[d]));
        check($sformatf("valid[%0d]", d), 32'(valid_v[d]), 32'(m_own[d] >= 0));
        check($sformatf("tmo[%0d]", d), 32'(tmo_v[d]), 32'(m_tmo[d]));
    endtask

    task automatic cycle(input logic r, input logic [3:0] rq, input logic rl);
        rst = r;
        req = rq;
        rel = rl;
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) model_step(d, r, rq, rl);
        #1;
        for (int d = 0; d < NDUT; d++) check_all(d);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            m_own[d] = -1; m_held[d] = 0; m_ptr[d] = 0; m_sel[d] = 0; m_tmo[d] = 1'b0;
        end
        rst = 1'b1;
        req = 4'b1111;
        rel = 1'b0;

        // reset with all requests asserted
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        check("rst_gnt", 32'(gnt_v[2]), 32'h0);
        check("rst_valid", 32'(valid_v[2]), 32'h0);
        cycle(1'b0, 4'b0100, 1'b0);
        check("first_gnt", 32'(gnt_v[2]), 32'h4);
        check("first_sel", 32'(sel_v[2]), 32'h2);

        // rotation with a release every cycle
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0);
        check("rot_sel0", 32'(sel_v[2]), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b0, 4'b1111, 1'b1);
            check($sformatf("rot_sel%0d", k), 32'(sel_v[2]), 32'(k % 4));
            check($sformatf("rot_valid%0d", k), 32'(valid_v[2]), 32'h1);
        end

        // timeout on HOLD_MAX=3 with two requesters
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        check("tmo_pre", 32'(tmo_v[0]), 32'h0);
        cycle(1'b0, 4'b0011, 1'b0);
        check("tmo_gnt", 32'(gnt_v[0]), 32'h2);
        check("tmo_pulse", 32'(tmo_v[0]), 32'h1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0011, 1'b0);
        check("tmo_back", 32'(gnt_v[0]), 32'h1);

        // sole requester on HOLD_MAX=2, then drop it
        cycle(1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b0, 4'b1000, 1'b0);
            check($sformatf("sole_gnt%0d", k), 32'(gnt_v[1]), 32'h8);
        end
        cycle(1'b0, 4'b0000, 1'b0);
        check("drop_gnt", 32'(gnt_v[1]), 32'h0);

        // release coinciding with timeout edge on HOLD_MAX=3
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0011, 1'b1);
        check("reltmo_gnt", 32'(gnt_v[0]), 32'h2);
        check("reltmo_tmo", 32'(tmo_v[0]), 32'h0);

        // mid-grant reset must also clear the rotation pointer
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0);
        cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b0, 4'b1111, 1'b1);
        check("mid_sel", 32'(sel_v[2]), 32'h2);
        cycle(1'b1, 4'b1111, 1'b0);
        check("mid_rst_gnt", 32'(gnt_v[2]), 32'h0);
        cycle(1'b0, 4'b1010, 1'b0);
        check("mid_after_gnt", 32'(gnt_v[2]), 32'h2);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            logic [3:0] rq;
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req;
            if ($urandom_range(0, 7) == 0) rq = 4'b1111;
            cycle(($urandom_range(0, 59) == 0), rq, ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
